// File: rtl/snn_image_loader_if.sv
// Byte-stream and core-side bus of the SNN image loader.
// The loader takes the slave modport; the UART/core side takes the master modport.
interface snn_image_loader_if #(
  parameter int ADDR_W = 10
);
  logic              rx_rdy;
  logic [7:0]        rx_data;
  logic [ADDR_W-1:0] core_addr;
  logic              core_q;
  logic              start;
  logic              core_done;
  logic              clr_err;
  logic [1:0]        err;
  logic [1:0]        n_full;
  logic              loading;

  modport master (
    output rx_rdy, rx_data, core_addr, core_done, clr_err,
    input  core_q, start, err, n_full, loading
  );

  modport slave (
    input  rx_rdy, rx_data, core_addr, core_done, clr_err,
    output core_q, start, err, n_full, loading
  );
endinterface

// File: rtl/snn_image_loader.sv
// Double-buffered UART image loader: unpacks received bytes into two
// bit-addressable banks and starts the SNN core once per complete image.
module snn_image_loader #(
  parameter int IMG_BITS    = 784,
  parameter int ADDR_W      = 10,
  parameter int TIMEOUT_CYC = 5_000_000,
  parameter int LSB_FIRST   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  snn_image_loader_if.slave   bus
);

  localparam int NBYTES = (IMG_BITS + 7) / 8;
  localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int IDLE_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(NBYTES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = (TIMEOUT_CYC > 0) ? IDLE_W'(TIMEOUT_CYC - 1) : '0;
  localparam logic [IDLE_W-1:0] IDLE_MAX  = '1;

  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic              wr_bank_q, wr_bank_d;
  logic              rd_bank_q, rd_bank_d;
  logic [1:0]        full_q, full_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              start_q, start_d;
  logic              pix_q, pix_d;
  logic [1:0]        err_q, err_d;
  logic [1:0]        n_full_q, n_full_d;
  logic              loading_q, loading_d;

  logic [7:0]        bank0_q [NBYTES];
  logic [7:0]        bank1_q [NBYTES];

  logic              wr_en_s, overrun_s, timeout_s, set_full_s, done_s;
  logic [CNT_W-1:0]  rd_idx_s;
  logic [2:0]        bit_idx_s;
  logic [7:0]        rd_byte_s;
  logic              in_range_s;

  // Load side: byte counter, write bank and inter-byte timeout
  always_comb begin
    wr_en_s    = bus.rx_rdy && !full_q[wr_bank_q];
    overrun_s  = bus.rx_rdy && full_q[wr_bank_q];
    // A byte arriving on the expiry cycle wins over the timeout
    timeout_s  = (TIMEOUT_CYC != 0) && !bus.rx_rdy && (cnt_q != '0) && (idle_q == IDLE_LAST);
    cnt_d      = cnt_q;
    wr_bank_d  = wr_bank_q;
    set_full_s = 1'b0;
    if (wr_en_s) begin
      if (cnt_q == CNT_LAST) begin
        cnt_d      = '0;
        wr_bank_d  = ~wr_bank_q;
        set_full_s = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else if (timeout_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q;
    end
    if (bus.rx_rdy) begin
      idle_d = '0;
    end else if (idle_q != IDLE_MAX) begin
      idle_d = idle_q + IDLE_W'(1);
    end else begin
      idle_d = idle_q;
    end
  end

  // Core-side FSM: issue start for a full bank, release it on core_done
  always_comb begin
    state_d   = state_q;
    start_d   = 1'b0;
    rd_bank_d = rd_bank_q;
    done_s    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (full_q[rd_bank_q]) begin
          start_d = 1'b1;
          state_d = S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (bus.core_done) begin
          done_s    = 1'b1;
          rd_bank_d = ~rd_bank_q;
          state_d   = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Full flags, sticky errors, status and pixel read
  always_comb begin
    full_d = full_q;
    // Writes only target a bank that is not full, so set and clear never collide
    if (done_s) begin
      full_d[rd_bank_q] = 1'b0;
    end else begin
      full_d = full_q;
    end
    if (set_full_s) begin
      full_d[wr_bank_q] = 1'b1;
    end else begin
      full_d = full_d;
    end
    err_d      = (bus.clr_err ? 2'b00 : err_q) | {timeout_s, overrun_s};
    n_full_d   = {1'b0, full_d[0]} + {1'b0, full_d[1]};
    loading_d  = (cnt_d != '0);
    rd_idx_s   = CNT_W'(bus.core_addr >> 3);
    in_range_s = ({1'b0, bus.core_addr} < (ADDR_W + 1)'(IMG_BITS));
    bit_idx_s  = (LSB_FIRST != 0) ? bus.core_addr[2:0] : (3'd7 - bus.core_addr[2:0]);
    rd_byte_s  = rd_bank_q ? bank1_q[rd_idx_s] : bank0_q[rd_idx_s];
    pix_d      = in_range_s & rd_byte_s[bit_idx_s];
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      full_q    <= 2'b00;
      cnt_q     <= '0;
      idle_q    <= '0;
      start_q   <= 1'b0;
      pix_q     <= 1'b0;
      err_q     <= 2'b00;
      n_full_q  <= 2'b00;
      loading_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      idle_q    <= idle_d;
      start_q   <= start_d;
      pix_q     <= pix_d;
      err_q     <= err_d;
      n_full_q  <= n_full_d;
      loading_q <= loading_d;
    end
  end

  // Image storage, contents intentionally not reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      if (wr_bank_q) begin
        bank1_q[cnt_q] <= bus.rx_data;
      end else begin
        bank0_q[cnt_q] <= bus.rx_data;
      end
    end
  end

  assign bus.core_q  = pix_q;
  assign bus.start   = start_q;
  assign bus.err     = err_q;
  assign bus.n_full  = n_full_q;
  assign bus.loading = loading_q;

endmodule
